// File: rtl/fir_tap_arbiter_if.sv
// Bundle of the config, engine and tap-BRAM signals around the FIR tap arbiter.
// Handshakes: a requester holds *_req (config also holds its fields) and the access is
// taken in any cycle where the matching *_gnt is 1; the response pulse follows one cycle later.
interface fir_tap_arbiter_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   cfg_req;
    logic                   cfg_we;
    logic [pADDR_WIDTH-1:0] cfg_addr;
    logic [pDATA_WIDTH-1:0] cfg_wdata;
    logic                   cfg_gnt;
    logic                   cfg_done;
    logic [pDATA_WIDTH-1:0] cfg_rdata;
    logic                   cfg_err;

    logic                   eng_req;
    logic [3:0]             eng_idx;
    logic                   eng_busy;
    logic                   eng_gnt;
    logic                   eng_rvalid;
    logic [pDATA_WIDTH-1:0] eng_rdata;

    logic [3:0]             tap_WE;
    logic                   tap_EN;
    logic [pADDR_WIDTH-1:0] tap_A;
    logic [pDATA_WIDTH-1:0] tap_Di;
    logic [pDATA_WIDTH-1:0] tap_Do;

    modport slave (
        input  cfg_req, cfg_we, cfg_addr, cfg_wdata,
        output cfg_gnt, cfg_done, cfg_rdata, cfg_err,
        input  eng_req, eng_idx, eng_busy,
        output eng_gnt, eng_rvalid, eng_rdata,
        output tap_WE, tap_EN, tap_A, tap_Di,
        input  tap_Do
    );

    modport master (
        output cfg_req, cfg_we, cfg_addr, cfg_wdata,
        input  cfg_gnt, cfg_done, cfg_rdata, cfg_err,
        output eng_req, eng_idx, eng_busy,
        input  eng_gnt, eng_rvalid, eng_rdata,
        input  tap_WE, tap_EN, tap_A, tap_Di,
        output tap_Do
    );
endinterface

// File: rtl/fir_tap_arbiter.sv
// Shares the single tap BRAM port between the config path and the FIR engine.
// Engine has priority; a starvation counter lets a waiting config access through.
module fir_tap_arbiter #(
    parameter int pADDR_WIDTH  = 12,
    parameter int pDATA_WIDTH  = 32,
    parameter int Tape_Num     = 11,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    fir_tap_arbiter_if.slave       bus,
    output logic [2:0]             dbg_rsp
);
    localparam int                     SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]          STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [pADDR_WIDTH-1:0] TAP_BYTES  = pADDR_WIDTH'(4 * Tape_Num);
    localparam logic [4:0]             TAP_CNT    = 5'(Tape_Num);

    typedef enum logic [2:0] {
        RSP_NONE    = 3'd0,
        RSP_ENG     = 3'd1,
        RSP_CFG_RD  = 3'd2,
        RSP_CFG_WR  = 3'd3,
        RSP_CFG_ERR = 3'd4
    } rsp_t;

    rsp_t          rsp, rsp_next;
    logic          eng_oor_q;
    logic [SW-1:0] starve_cnt;
    logic          cfg_elig, cfg_win, eng_win;
    logic          cfg_addr_ok, eng_idx_ok;

    // A write is held off while the engine is mid-block; reads may always compete.
    assign cfg_elig    = bus.cfg_req && (!bus.cfg_we || !bus.eng_busy);
    assign cfg_win     = !axis_rst && cfg_elig && (!bus.eng_req || starve_cnt == STARVE_MAX);
    assign eng_win     = !axis_rst && bus.eng_req && !cfg_win;
    assign cfg_addr_ok = (bus.cfg_addr[1:0] == 2'b00) && (bus.cfg_addr < TAP_BYTES);
    assign eng_idx_ok  = ({1'b0, bus.eng_idx} < TAP_CNT);

    assign bus.cfg_gnt = cfg_win;
    assign bus.eng_gnt = eng_win;
    assign dbg_rsp     = rsp;

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            starve_cnt <= '0;
        end else if (!bus.cfg_req || cfg_win) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_comb begin
        bus.tap_EN = 1'b0;
        bus.tap_WE = 4'h0;
        bus.tap_A  = '0;
        bus.tap_Di = '0;
        if (cfg_win && cfg_addr_ok) begin
            bus.tap_EN = 1'b1;
            bus.tap_A  = {bus.cfg_addr[pADDR_WIDTH-1:2], 2'b00};
            if (bus.cfg_we) begin
                bus.tap_WE = 4'hF;
                bus.tap_Di = bus.cfg_wdata;
            end
        end else if (eng_win && eng_idx_ok) begin
            bus.tap_EN = 1'b1;
            bus.tap_A  = pADDR_WIDTH'({bus.eng_idx, 2'b00});
        end
    end

    // Response tag: one entry per grant, consumed the following cycle.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            rsp       <= RSP_NONE;
            eng_oor_q <= 1'b0;
        end else begin
            rsp       <= rsp_next;
            eng_oor_q <= eng_win && !eng_idx_ok;
        end
    end

    always_comb begin
        rsp_next = RSP_NONE;
        if (cfg_win) begin
            if (!cfg_addr_ok)    rsp_next = RSP_CFG_ERR;
            else if (bus.cfg_we) rsp_next = RSP_CFG_WR;
            else                 rsp_next = RSP_CFG_RD;
        end else if (eng_win) begin
            rsp_next = RSP_ENG;
        end
    end

    // An out-of-range engine fetch never touched the BRAM, so its data is forced to 0.
    always_comb begin
        bus.cfg_done   = 1'b0;
        bus.cfg_err    = 1'b0;
        bus.cfg_rdata  = '0;
        bus.eng_rvalid = 1'b0;
        bus.eng_rdata  = '0;
        case (rsp)
            RSP_ENG: begin
                bus.eng_rvalid = 1'b1;
                if (!eng_oor_q) bus.eng_rdata = bus.tap_Do;
            end
            RSP_CFG_RD: begin
                bus.cfg_done  = 1'b1;
                bus.cfg_rdata = bus.tap_Do;
            end
            RSP_CFG_WR: begin
                bus.cfg_done = 1'b1;
            end
            RSP_CFG_ERR: begin
                bus.cfg_done = 1'b1;
                bus.cfg_err  = 1'b1;
            end
            default: begin
                bus.cfg_done = 1'b0;
            end
        endcase
    end
endmodule
